// File: rtl/serial_rx_pkg.sv
// -----------------------------------------------------------------------------
// serial_rx_pkg
// Shared definitions for the 8N1 serial receiver: the FSM state type, the
// debug display codes, counter widths and the display encoder.
// -----------------------------------------------------------------------------
package serial_rx_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        ERROR = 3'd4
    } rx_state_e;

    // Frame geometry
    localparam int DATA_BITS = 8;
    localparam int IDX_W     = 3;
    // Cycle counter width; covers CLKS_PER_BIT up to 1023
    localparam int CNT_W     = 10;

    // Debug display codes: bit 4 flags idle/error, bits 3:0 carry progress
    localparam logic [4:0] DISP_IDLE  = 5'b10000;
    localparam logic [4:0] DISP_START = 5'b00000;
    localparam logic [4:0] DISP_STOP  = 5'b01001;
    localparam logic [4:0] DISP_ERR   = 5'b11111;

    // Map FSM state and data-bit index onto the 5-bit status display.
    // While receiving data the display shows 1..8 for bit index 0..7.
    function automatic logic [4:0] disp_encode(input rx_state_e        state,
                                               input logic [IDX_W-1:0] bit_idx);
        logic [4:0] disp;
        disp = DISP_IDLE;
        case (state)
            IDLE:    disp = DISP_IDLE;
            START:   disp = DISP_START;
            DATA:    disp = {1'b0, 4'd1 + {1'b0, bit_idx}};
            STOP:    disp = DISP_STOP;
            ERROR:   disp = DISP_ERR;
            default: disp = DISP_IDLE;
        endcase
        return disp;
    endfunction

endpackage

// File: rtl/serial_rx_sync.sv
// -----------------------------------------------------------------------------
// serial_rx_sync
// Two-flop synchroniser for the asynchronous serial line. Both stages reset
// to 1 so that the receiver sees an idle (high) line straight out of reset.
//
// Ports:
//   clk_i   system clock (rising edge)
//   rst_ni  asynchronous active-low reset
//   d_i     asynchronous serial line
//   q_o     line synchronised to clk_i (two cycles of latency)
// -----------------------------------------------------------------------------
module serial_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous line, idle-high after reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serial_rx.sv
// -----------------------------------------------------------------------------
// serial_rx
// UART-style 8N1 receiver. Synchronises the serial line, finds the start bit,
// samples 8 data bits LSB first and checks the stop bit. Only a correctly
// framed byte reaches ledData; a bad stop bit parks the FSM in ERROR until the
// line returns high.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit, 1..1023
//
// Ports:
//   clk2          system clock (rising edge)
//   rst_n         asynchronous active-low reset
//   transmission  serial line, idle high, asynchronous to clk2
//   display       status: bit 4 idle/error flag, bits 3:0 bit index or code
//   ledData       last correctly framed byte
// -----------------------------------------------------------------------------
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk2,
    input  logic       rst_n,
    input  logic       transmission,
    output logic [4:0] display,
    output logic [7:0] ledData
);

    localparam logic [CNT_W-1:0] HALF_BIT_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE      = 3'd1;
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_dly_q;
    logic                 cnt_zero_s;
    rx_state_e            state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] led_q,     led_d;
    logic [4:0]           disp_q,    disp_d;

    serial_rx_sync u_sync (
        .clk_i  (clk2),
        .rst_ni (rst_n),
        .d_i    (transmission),
        .q_o    (rx_s)
    );

    // One-cycle delayed copy of the synchronised line used for bit sampling.
    // IDLE burns the first cycle of the start bit just detecting it, so every
    // later decision happens one cycle after the intended point; sampling the
    // delayed copy cancels that and keeps the sample floor(N/2) cycles into
    // each bit, which is what lets N=1 and N=2 frames be received at all.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            rx_dly_q <= 1'b1;
        end else begin
            rx_dly_q <= rx_s;
        end
    end

    assign cnt_zero_s = (cnt_q == '0);

    // Next-state, counter, shift-register and output-byte logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        led_d     = led_q;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = HALF_BIT_CNT;
                end else begin
                    state_d = IDLE;
                end
            end

            START: begin
                if (cnt_zero_s) begin
                    if (!rx_dly_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                        cnt_d     = FULL_BIT_CNT;
                    end else begin
                        // Line was back high mid start bit: a glitch
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            DATA: begin
                if (cnt_zero_s) begin
                    // LSB arrives first, so shift in from the MSB side
                    shift_d   = {rx_dly_q, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + IDX_ONE;
                    cnt_d     = FULL_BIT_CNT;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            STOP: begin
                if (cnt_zero_s) begin
                    if (rx_dly_q) begin
                        led_d   = shift_q;
                        state_d = IDLE;
                    end else begin
                        state_d = ERROR;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ERROR: begin
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = ERROR;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Display code follows the state being entered so it stays registered
    always_comb begin
        disp_d = disp_encode(state_d, bit_idx_d);
    end

    // FSM, counters, shift register and registered outputs
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            led_q     <= '0;
            disp_q    <= DISP_IDLE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            led_q     <= led_d;
            disp_q    <= disp_d;
        end
    end

    assign display = disp_q;
    assign ledData = led_q;

endmodule

// File: tb/tb_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_rx
// Directed bench for serial_rx. Two instances share clock and reset: one at
// one clock per bit, one at sixteen clocks per bit. Line bits are driven on
// the falling edge, outputs are sampled on the falling edge before driving.
// -----------------------------------------------------------------------------
module tb_serial_rx;

    logic       clk2;
    logic       rst_n;
    logic       tx1;
    logic       tx16;
    logic [4:0] display1;
    logic [4:0] display16;
    logic [7:0] led1;
    logic [7:0] led16;

    int n_vec;
    int n_err;

    logic [9:0] frame;
    // Expected display of the N=1 receiver at falling edge j after the start
    // bit is driven (index 0 unused)
    logic [4:0] exp_disp [0:13];

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    serial_rx #(.CLKS_PER_BIT(1)) dut1 (
        .clk2         (clk2),
        .rst_n        (rst_n),
        .transmission (tx1),
        .display      (display1),
        .ledData      (led1)
    );

    serial_rx #(.CLKS_PER_BIT(16)) dut16 (
        .clk2         (clk2),
        .rst_n        (rst_n),
        .transmission (tx16),
        .display      (display16),
        .ledData      (led16)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One frame on the N=1 line, optional extra low cycles, then line high
    task automatic send_n1(input logic [7:0] data, input logic stop_bit, input int tail_low);
        logic [9:0] fr;
        fr = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk2);
            tx1 = fr[i];
        end
        for (int i = 0; i < tail_low; i++) begin
            @(negedge clk2);
            tx1 = 1'b0;
        end
        @(negedge clk2);
        tx1 = 1'b1;
    endtask

    // One frame on the N=16 line, no trailing idle; checks the exact update
    // edge: 3 + 8 + 144 = 155 edges after the first capture edge
    task automatic send_n16(input logic [7:0] data, input logic [7:0] old_led,
                            input logic [7:0] new_led);
        logic [9:0] fr;
        fr = {1'b1, data, 1'b0};
        for (int j = 0; j < 160; j++) begin
            @(negedge clk2);
            if (j == 155) check_eq("n16_led_before", led16, old_led);
            if (j == 156) check_eq("n16_led_after", led16, new_led);
            tx16 = fr[j / 16];
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_disp = '{5'd16, 5'd16, 5'd16, 5'd0, 5'd1, 5'd2, 5'd3,
                     5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd16};

        // Reset with line idle
        rst_n = 1'b0;
        tx1   = 1'b1;
        tx16  = 1'b1;
        repeat (3) @(negedge clk2);
        check_eq("rst_disp1", display1, 5'd16);
        check_eq("rst_led1", led1, 8'h00);
        check_eq("rst_disp16", display16, 5'd16);
        check_eq("rst_led16", led16, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk2);
        check_eq("idle_disp1", display1, 5'd16);
        check_eq("idle_led1", led1, 8'h00);

        // Nominal frame 0x91 at N=1 with display walk
        frame = {1'b1, 8'h91, 1'b0};
        @(negedge clk2);
        tx1 = frame[0];
        for (int j = 1; j <= 13; j++) begin
            @(negedge clk2);
            check_eq($sformatf("nom_disp_%0d", j), display1, exp_disp[j]);
            if (j == 12) check_eq("nom_led_before", led1, 8'h00);
            if (j == 13) check_eq("nom_led_after", led1, 8'h91);
            tx1 = (j < 10) ? frame[j] : 1'b1;
        end

        // Framing error: 0xFF with stop bit 0, line held low 3 more cycles
        repeat (3) @(negedge clk2);
        send_n1(8'hFF, 1'b0, 3);
        check_eq("ferr_disp", display1, 5'd31);
        check_eq("ferr_led", led1, 8'h91);
        repeat (2) @(negedge clk2);
        check_eq("ferr_hold", display1, 5'd31);
        @(negedge clk2);
        check_eq("ferr_exit_disp", display1, 5'd16);
        check_eq("ferr_exit_led", led1, 8'h91);

        // Reset during data bit 4 of a frame
        repeat (3) @(negedge clk2);
        frame = {1'b1, 8'hC3, 1'b0};
        @(negedge clk2);
        tx1 = frame[0];
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk2);
            tx1 = frame[j];
        end
        @(negedge clk2);
        check_eq("mid_disp_bit4", display1, 5'd5);
        rst_n = 1'b0;
        tx1   = 1'b1;
        #1;
        check_eq("mid_rst_disp", display1, 5'd16);
        check_eq("mid_rst_led", led1, 8'h00);
        repeat (2) @(negedge clk2);
        rst_n = 1'b1;
        repeat (3) @(negedge clk2);
        send_n1(8'h3C, 1'b1, 0);
        repeat (3) @(negedge clk2);
        check_eq("post_rst_led", led1, 8'h3C);
        check_eq("post_rst_disp", display1, 5'd16);

        // Glitch rejection at N=16: 4-cycle low pulse
        repeat (5) @(negedge clk2);
        tx16 = 1'b0;
        repeat (4) @(negedge clk2);
        tx16 = 1'b1;
        @(negedge clk2);
        check_eq("glitch_start_disp", display16, 5'd0);
        repeat (7) @(negedge clk2);
        check_eq("glitch_back_idle", display16, 5'd16);
        repeat (20) @(negedge clk2);
        check_eq("glitch_led", led16, 8'h00);

        // Full frame 0xA5 at N=16, then back-to-back 0x91 and 0x5A
        send_n16(8'hA5, 8'h00, 8'hA5);
        repeat (10) @(negedge clk2);
        send_n16(8'h91, 8'hA5, 8'h91);
        send_n16(8'h5A, 8'h91, 8'h5A);
        @(negedge clk2);
        tx16 = 1'b1;

        // Output holds with an idle line
        repeat (60) @(negedge clk2);
        check_eq("hold_led16", led16, 8'h5A);
        check_eq("hold_disp16", display16, 5'd16);
        check_eq("hold_led1", led1, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
